// File: rtl/icnd2110_pkg.sv
// Shared ICND2110 framing constants and decoder state encoding.
// The receiver and the existing transmitter both import this package.
package icnd2110_pkg;

   localparam int START_ONES      = 128;
   localparam int BLANK_BITS      = 16;
   localparam int WORDS_PER_GROUP = 6;
   localparam int WORDS_PER_CHIP  = 12;
   localparam int END_ONES        = 145;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_BLANK_PRE,
      ST_REG,
      ST_BLANK,
      ST_DATA_LO,
      ST_BLANK_MID,
      ST_DATA_HI,
      ST_SEP,
      ST_END
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/icnd2110_sync_edge.sv
// Brings the ICND2110 serial clock and data into the clk domain and flags
// each rising edge of the serial clock as a one-cycle sample pulse.
module icnd2110_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic clock_in,
   input  logic data_in,
   output logic sample,
   output logic bit_value
);

   logic [1:0] clk_sync;
   logic [1:0] dat_sync;
   logic       clk_prev;

   // Both lines use the same depth, so the data seen at the detected edge is
   // the value driven at the preceding falling edge of clock_in.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync <= 2'b00;
         dat_sync <= 2'b00;
         clk_prev <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], clock_in};
         dat_sync <= {dat_sync[0], data_in};
         clk_prev <= clk_sync[1];
      end
   end

   assign sample    = clk_sync[1] & ~clk_prev;
   assign bit_value = dat_sync[1];

endmodule

// File: rtl/icnd2110_in.sv
// ICND2110 serial frame receiver: decodes the register word and per-chip
// channel words from the serial stream and reports frame completion/errors.
module icnd2110_in
   import icnd2110_pkg::*;
#(
   parameter int WORD_COUNT        = 336,
   parameter int ADDRESS_BUS_WIDTH = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clock_in,
   input  logic                       data_in,
   output logic [15:0]                word_data,
   output logic [ADDRESS_BUS_WIDTH:0] word_address,
   output logic                       word_strobe,
   output logic [15:0]                cfg_reg,
   output logic                       cfg_valid,
   output logic [7:0]                 chip_count,
   output logic                       frame_done,
   output logic                       frame_error
);

   // Address arithmetic is done at least 16 bits wide so the WORD_COUNT
   // bound is checked before the result is narrowed to the port width.
   localparam int CALC_W = (ADDRESS_BUS_WIDTH + 1 > 16) ? ADDRESS_BUS_WIDTH + 1 : 16;

   localparam logic [3:0] BLANK_LAST = 4'(BLANK_BITS - 1);
   localparam logic [3:0] WORD_LAST  = 4'd15;
   localparam logic [2:0] GROUP_LAST = 3'(WORDS_PER_GROUP - 1);
   localparam logic [3:0] OFF_LO     = 4'(WORDS_PER_GROUP - 1);
   localparam logic [3:0] OFF_HI     = 4'(WORDS_PER_CHIP - 1);
   localparam logic [7:0] START_MIN  = 8'(START_ONES);
   localparam logic [7:0] END_MIN    = 8'(END_ONES);

   logic sample;
   logic bit_value;

   icnd2110_sync_edge u_sync (
      .clk       (clk),
      .rst       (rst),
      .clock_in  (clock_in),
      .data_in   (data_in),
      .sample    (sample),
      .bit_value (bit_value)
   );

   state_t      state, state_n;
   logic [7:0]  run_cnt, run_cnt_n;
   logic [3:0]  bit_cnt, bit_cnt_n;
   logic [2:0]  word_idx, word_idx_n;
   logic [7:0]  chip, chip_n;
   logic [14:0] shift, shift_n;

   logic [15:0]                word_data_n;
   logic [ADDRESS_BUS_WIDTH:0] word_address_n;
   logic [15:0]                cfg_reg_n;
   logic [7:0]                 chip_count_n;
   logic                       word_strobe_n;
   logic                       cfg_valid_n;
   logic                       frame_done_n;
   logic                       frame_error_n;

   logic [15:0]       word_full;
   logic [3:0]        grp_top;
   logic [CALC_W-1:0] addr;

   assign word_full = {shift, bit_value};
   assign grp_top   = (state == ST_DATA_HI) ? OFF_HI : OFF_LO;
   assign addr      = CALC_W'(chip) * CALC_W'(WORDS_PER_CHIP) + CALC_W'(grp_top)
                      - CALC_W'(word_idx);

   // word_strobe, cfg_valid, frame_done and frame_error are single-cycle
   // pulses with no backpressure; the consumer captures data on the pulse.
   always_comb begin
      state_n        = state;
      run_cnt_n      = run_cnt;
      bit_cnt_n      = bit_cnt;
      word_idx_n     = word_idx;
      chip_n         = chip;
      shift_n        = shift;
      word_data_n    = word_data;
      word_address_n = word_address;
      cfg_reg_n      = cfg_reg;
      chip_count_n   = chip_count;
      word_strobe_n  = 1'b0;
      cfg_valid_n    = 1'b0;
      frame_done_n   = 1'b0;
      frame_error_n  = 1'b0;

      if (sample) begin
         unique case (state)
            ST_IDLE: begin
               if (bit_value) begin
                  run_cnt_n = sat_inc8(run_cnt);
               end else if (run_cnt >= START_MIN) begin
                  state_n   = ST_BLANK_PRE;
                  bit_cnt_n = 4'd1;
                  run_cnt_n = 8'd0;
               end else begin
                  run_cnt_n = 8'd0;
               end
            end

            ST_BLANK_PRE, ST_BLANK, ST_BLANK_MID: begin
               if (bit_value) begin
                  frame_error_n = 1'b1;
                  state_n       = ST_IDLE;
                  run_cnt_n     = 8'd0;
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
                  if (bit_cnt == BLANK_LAST) begin
                     bit_cnt_n  = 4'd0;
                     word_idx_n = 3'd0;
                     if (state == ST_BLANK_PRE)
                        state_n = ST_REG;
                     else if (state == ST_BLANK)
                        state_n = ST_DATA_LO;
                     else
                        state_n = ST_DATA_HI;
                  end
               end
            end

            ST_REG: begin
               shift_n   = word_full[14:0];
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == WORD_LAST) begin
                  cfg_reg_n   = word_full;
                  cfg_valid_n = 1'b1;
                  chip_n      = 8'd0;
                  bit_cnt_n   = 4'd0;
                  state_n     = ST_BLANK;
               end
            end

            ST_DATA_LO, ST_DATA_HI: begin
               shift_n   = word_full[14:0];
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == WORD_LAST) begin
                  bit_cnt_n = 4'd0;
                  if (addr >= CALC_W'(WORD_COUNT)) begin
                     frame_error_n = 1'b1;
                     state_n       = ST_IDLE;
                     run_cnt_n     = 8'd0;
                  end else begin
                     word_data_n    = word_full;
                     word_address_n = addr[ADDRESS_BUS_WIDTH:0];
                     word_strobe_n  = 1'b1;
                     word_idx_n     = word_idx + 3'd1;
                     if (word_idx == GROUP_LAST) begin
                        word_idx_n = 3'd0;
                        if (state == ST_DATA_LO) begin
                           state_n = ST_BLANK_MID;
                        end else begin
                           chip_n  = chip + 8'd1;
                           state_n = ST_SEP;
                        end
                     end
                  end
               end
            end

            ST_SEP: begin
               if (bit_value) begin
                  state_n   = ST_END;
                  run_cnt_n = 8'd1;
               end else begin
                  state_n   = ST_BLANK;
                  bit_cnt_n = 4'd1;
               end
            end

            ST_END: begin
               if (bit_value) begin
                  run_cnt_n = sat_inc8(run_cnt);
               end else begin
                  if (run_cnt >= END_MIN) begin
                     chip_count_n = chip;
                     frame_done_n = 1'b1;
                  end else begin
                     frame_error_n = 1'b1;
                  end
                  state_n   = ST_IDLE;
                  run_cnt_n = 8'd0;
               end
            end

            default: begin
               state_n   = ST_IDLE;
               run_cnt_n = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         run_cnt      <= 8'd0;
         bit_cnt      <= 4'd0;
         word_idx     <= 3'd0;
         chip         <= 8'd0;
         shift        <= 15'd0;
         word_data    <= 16'd0;
         word_address <= '0;
         word_strobe  <= 1'b0;
         cfg_reg      <= 16'd0;
         cfg_valid    <= 1'b0;
         chip_count   <= 8'd0;
         frame_done   <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         state        <= state_n;
         run_cnt      <= run_cnt_n;
         bit_cnt      <= bit_cnt_n;
         word_idx     <= word_idx_n;
         chip         <= chip_n;
         shift        <= shift_n;
         word_data    <= word_data_n;
         word_address <= word_address_n;
         word_strobe  <= word_strobe_n;
         cfg_reg      <= cfg_reg_n;
         cfg_valid    <= cfg_valid_n;
         chip_count   <= chip_count_n;
         frame_done   <= frame_done_n;
         frame_error  <= frame_error_n;
      end
   end

endmodule

// File: tb/tb_icnd2110_in.sv
// Self-checking bench for icnd2110_in: serial frames are driven bit by bit
// and decoded words are matched against a queue of expected {address, data}.
module tb_icnd2110_in;

   localparam int AW       = 13;
   localparam int HALF_BIT = 20;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          clock_in = 1'b0;
   logic          data_in  = 1'b0;
   logic [15:0]   word_data;
   logic [AW-1:0] word_address;
   logic          word_strobe;
   logic [15:0]   cfg_reg;
   logic          cfg_valid;
   logic [7:0]    chip_count;
   logic          frame_done;
   logic          frame_error;

   int checks = 0;
   int errors = 0;

   logic [AW+15:0] exp_q[$];
   logic [15:0]    cfg_q[$];

   int            strobe_cnt = 0;
   int            cfg_cnt    = 0;
   int            done_cnt   = 0;
   int            err_cnt    = 0;
   logic [AW-1:0] last_addr  = '0;

   icnd2110_in #(
      .WORD_COUNT        (336),
      .ADDRESS_BUS_WIDTH (12)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clock_in     (clock_in),
      .data_in      (data_in),
      .word_data    (word_data),
      .word_address (word_address),
      .word_strobe  (word_strobe),
      .cfg_reg      (cfg_reg),
      .cfg_valid    (cfg_valid),
      .chip_count   (chip_count),
      .frame_done   (frame_done),
      .frame_error  (frame_error)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [AW+15:0] exp_w;
      logic [15:0]    exp_c;
      if (!rst) begin
         if (word_strobe) begin
            strobe_cnt++;
            last_addr = word_address;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: got addr %0d data %h, required no strobe",
                        word_address, word_data);
            end else begin
               exp_w = exp_q.pop_front();
               if ({word_address, word_data} !== exp_w) begin
                  errors++;
                  $display("FAIL strobe: got addr %0d data %h, required addr %0d data %h",
                           word_address, word_data, exp_w[AW+15:16], exp_w[15:0]);
               end
            end
         end
         if (cfg_valid) begin
            cfg_cnt++;
            checks++;
            if (cfg_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_cfg: got %h, required no cfg_valid", cfg_reg);
            end else begin
               exp_c = cfg_q.pop_front();
               if (cfg_reg !== exp_c) begin
                  errors++;
                  $display("FAIL cfg: got %h, required %h", cfg_reg, exp_c);
               end
            end
         end
         if (frame_done)  done_cnt++;
         if (frame_error) err_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_bit(input logic b);
      clock_in = 1'b0;
      data_in  = b;
      #HALF_BIT;
      clock_in = 1'b1;
      #HALF_BIT;
   endtask

   task automatic send_run(input logic b, input int n);
      for (int i = 0; i < n; i++) send_bit(b);
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) send_bit(w[i]);
   endtask

   // Sends n words of one group, first word at offset 'top' counting down.
   task automatic send_group(input int chip, input int top, input int n,
                             input logic [15:0] base, input bit push);
      for (int k = 0; k < n; k++) begin
         logic [AW-1:0] a;
         logic [15:0]   d;
         a = AW'(chip * 12 + top - k);
         d = 16'(chip * 12 + top - k) ^ base;
         if (push) exp_q.push_back({a, d});
         send_word(d);
      end
   endtask

   task automatic send_chip(input int chip, input logic [15:0] base, input bit push);
      send_run(1'b0, 16);
      send_group(chip, 5, 6, base, push);
      send_run(1'b0, 16);
      send_group(chip, 11, 6, base, push);
   endtask

   // end_ones == 0 leaves the end marker off entirely.
   task automatic send_frame(input int start_ones, input int nchips, input logic [15:0] cfg,
                             input int end_ones, input logic [15:0] base, input bit push);
      send_run(1'b1, start_ones);
      send_run(1'b0, 16);
      if (push) cfg_q.push_back(cfg);
      send_word(cfg);
      for (int c = 0; c < nchips; c++) send_chip(c, base, push);
      if (end_ones > 0) begin
         send_run(1'b1, end_ones);
         send_bit(1'b0);
      end
      #200;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      checks++; if (word_data    !== 16'd0) begin errors++; $display("FAIL rst_word_data: got %h, required 0", word_data); end
      checks++; if (word_address !== '0)    begin errors++; $display("FAIL rst_word_address: got %0d, required 0", word_address); end
      checks++; if (word_strobe  !== 1'b0)  begin errors++; $display("FAIL rst_word_strobe: got %b, required 0", word_strobe); end
      checks++; if (cfg_reg      !== 16'd0) begin errors++; $display("FAIL rst_cfg_reg: got %h, required 0", cfg_reg); end
      checks++; if (cfg_valid    !== 1'b0)  begin errors++; $display("FAIL rst_cfg_valid: got %b, required 0", cfg_valid); end
      checks++; if (chip_count   !== 8'd0)  begin errors++; $display("FAIL rst_chip_count: got %0d, required 0", chip_count); end
      checks++; if (frame_done   !== 1'b0)  begin errors++; $display("FAIL rst_frame_done: got %b, required 0", frame_done); end
      checks++; if (frame_error  !== 1'b0)  begin errors++; $display("FAIL rst_frame_error: got %b, required 0", frame_error); end
      rst = 1'b0;
   endtask

   task automatic test_single_chip();
      int s0, c0, d0, e0;
      s0 = strobe_cnt; c0 = cfg_cnt; d0 = done_cnt; e0 = err_cnt;
      send_frame(130, 1, 16'h0817, 150, 16'h0000, 1'b1);
      checks++; if (strobe_cnt - s0 != 12) begin errors++; $display("FAIL single_strobes: got %0d, required 12", strobe_cnt - s0); end
      checks++; if (last_addr !== 13'd6)   begin errors++; $display("FAIL single_last_addr: got %0d, required 6", last_addr); end
      checks++; if (cfg_cnt - c0 != 1)     begin errors++; $display("FAIL single_cfg_count: got %0d, required 1", cfg_cnt - c0); end
      checks++; if (cfg_reg !== 16'h0817)  begin errors++; $display("FAIL single_cfg_reg: got %h, required 0817", cfg_reg); end
      checks++; if (done_cnt - d0 != 1)    begin errors++; $display("FAIL single_done: got %0d, required 1", done_cnt - d0); end
      checks++; if (err_cnt - e0 != 0)     begin errors++; $display("FAIL single_error: got %0d, required 0", err_cnt - e0); end
      checks++; if (chip_count !== 8'd1)   begin errors++; $display("FAIL single_chip_count: got %0d, required 1", chip_count); end
   endtask

   task automatic test_full_frame();
      int s0, d0, e0;
      logic [15:0] base;
      base = 16'($urandom_range(0, 16'hFFFF));
      s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
      send_frame(140, 28, 16'h5A3C, 146, base, 1'b1);
      checks++; if (strobe_cnt - s0 != 336) begin errors++; $display("FAIL full_strobes: got %0d, required 336", strobe_cnt - s0); end
      checks++; if (last_addr !== 13'd330)  begin errors++; $display("FAIL full_last_addr: got %0d, required 330", last_addr); end
      checks++; if (chip_count !== 8'd28)   begin errors++; $display("FAIL full_chip_count: got %0d, required 28", chip_count); end
      checks++; if (done_cnt - d0 != 1)     begin errors++; $display("FAIL full_done: got %0d, required 1", done_cnt - d0); end
      checks++; if (err_cnt - e0 != 0)      begin errors++; $display("FAIL full_error: got %0d, required 0", err_cnt - e0); end
   endtask

   task automatic test_short_start();
      int s0, c0, d0, e0;
      s0 = strobe_cnt; c0 = cfg_cnt; d0 = done_cnt; e0 = err_cnt;
      send_frame(127, 2, 16'hBEEF, 0, 16'($urandom_range(0, 16'hFFFF)), 1'b0);
      send_run(1'b0, 20);
      #200;
      checks++; if (strobe_cnt - s0 != 0) begin errors++; $display("FAIL short_start_strobes: got %0d, required 0", strobe_cnt - s0); end
      checks++; if (cfg_cnt - c0 != 0)    begin errors++; $display("FAIL short_start_cfg: got %0d, required 0", cfg_cnt - c0); end
      checks++; if (done_cnt - d0 != 0)   begin errors++; $display("FAIL short_start_done: got %0d, required 0", done_cnt - d0); end
      checks++; if (err_cnt - e0 != 0)    begin errors++; $display("FAIL short_start_error: got %0d, required 0", err_cnt - e0); end
   endtask

   task automatic test_blank_glitch();
      int s0, d0, e0;
      logic [15:0] base;
      base = 16'($urandom_range(0, 16'hFFFF));
      s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
      send_run(1'b1, 160);
      send_run(1'b0, 16);
      cfg_q.push_back(16'h5A3C);
      send_word(16'h5A3C);
      send_run(1'b0, 16);
      send_group(0, 5, 6, base, 1'b1);
      send_run(1'b0, 5);
      send_bit(1'b1);
      send_run(1'b0, 20);
      #200;
      checks++; if (err_cnt - e0 != 1)    begin errors++; $display("FAIL glitch_error: got %0d, required 1", err_cnt - e0); end
      checks++; if (done_cnt - d0 != 0)   begin errors++; $display("FAIL glitch_done: got %0d, required 0", done_cnt - d0); end
      checks++; if (strobe_cnt - s0 != 6) begin errors++; $display("FAIL glitch_strobes: got %0d, required 6", strobe_cnt - s0); end
      checks++; if (chip_count !== 8'd28) begin errors++; $display("FAIL glitch_chip_count: got %0d, required 28", chip_count); end
      send_frame(150, 2, 16'h1357, 145, base, 1'b1);
      checks++; if (done_cnt - d0 != 1)    begin errors++; $display("FAIL recover_done: got %0d, required 1", done_cnt - d0); end
      checks++; if (chip_count !== 8'd2)   begin errors++; $display("FAIL recover_chip_count: got %0d, required 2", chip_count); end
      checks++; if (err_cnt - e0 != 1)     begin errors++; $display("FAIL recover_error: got %0d, required 1", err_cnt - e0); end
      checks++; if (strobe_cnt - s0 != 30) begin errors++; $display("FAIL recover_strobes: got %0d, required 30", strobe_cnt - s0); end
   endtask

   task automatic test_short_end();
      int s0, d0, e0;
      s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
      send_frame(128, 1, 16'h2468, 144, 16'h00F0, 1'b1);
      checks++; if (err_cnt - e0 != 1)     begin errors++; $display("FAIL short_end_error: got %0d, required 1", err_cnt - e0); end
      checks++; if (done_cnt - d0 != 0)    begin errors++; $display("FAIL short_end_done: got %0d, required 0", done_cnt - d0); end
      checks++; if (chip_count !== 8'd2)   begin errors++; $display("FAIL short_end_chip_count: got %0d, required 2", chip_count); end
      checks++; if (strobe_cnt - s0 != 12) begin errors++; $display("FAIL short_end_strobes: got %0d, required 12", strobe_cnt - s0); end
   endtask

   task automatic test_reset_mid_frame();
      int s0, d0;
      logic [15:0] base;
      base = 16'($urandom_range(0, 16'hFFFF));
      s0 = strobe_cnt;
      send_run(1'b1, 135);
      send_run(1'b0, 16);
      cfg_q.push_back(16'hC0DE);
      send_word(16'hC0DE);
      send_run(1'b0, 16);
      send_group(0, 5, 6, base, 1'b1);
      send_run(1'b0, 16);
      send_group(0, 11, 3, base, 1'b1);
      #200;
      apply_reset();
      checks++; if (chip_count !== 8'd0) begin errors++; $display("FAIL mid_rst_chip_count: got %0d, required 0", chip_count); end
      checks++; if (cfg_reg !== 16'd0)   begin errors++; $display("FAIL mid_rst_cfg_reg: got %h, required 0", cfg_reg); end
      checks++; if (word_data !== 16'd0) begin errors++; $display("FAIL mid_rst_word_data: got %h, required 0", word_data); end
      send_group(0, 8, 3, base, 1'b0);
      send_run(1'b0, 20);
      #200;
      checks++; if (strobe_cnt - s0 != 9) begin errors++; $display("FAIL mid_rst_strobes: got %0d, required 9", strobe_cnt - s0); end
      d0 = done_cnt;
      send_frame(129, 1, 16'h0F0F, 147, base, 1'b1);
      checks++; if (done_cnt - d0 != 1)    begin errors++; $display("FAIL mid_rst_done: got %0d, required 1", done_cnt - d0); end
      checks++; if (chip_count !== 8'd1)   begin errors++; $display("FAIL mid_rst_chip_count2: got %0d, required 1", chip_count); end
      checks++; if (strobe_cnt - s0 != 21) begin errors++; $display("FAIL mid_rst_strobes2: got %0d, required 21", strobe_cnt - s0); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_chip();
      test_full_frame();
      test_short_start();
      test_blank_glitch();
      test_short_end();
      test_reset_mid_frame();
      #200;
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL word_queue_left: got %0d pending, required 0", exp_q.size()); end
      checks++; if (cfg_q.size() != 0) begin errors++; $display("FAIL cfg_queue_left: got %0d pending, required 0", cfg_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
